// File: rtl/biu_slave_burst.sv
// Bus-side slave bridging a shared tri-state burst bus to a simple
// request/ready slave interface, with write buffering and read timeout.
module biu_slave_burst #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN  = 32'h100,
    parameter int                    LEN_WIDTH  = 2,
    parameter int                    ADDR_INC   = DATA_WIDTH / 8,
    parameter int                    TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  n_rst,
    inout  wire  [ADDR_WIDTH-1:0] bus_address,
    inout  wire  [DATA_WIDTH-1:0] bus_data,
    inout  wire  [LEN_WIDTH+2:0]  bus_control,
    output logic [ADDR_WIDTH-1:0] biu_address,
    output logic [DATA_WIDTH-1:0] biu_data_in,
    output logic                  biu_rnw,
    output logic                  biu_en,
    input  logic                  biu_ready,
    input  logic                  biu_data_valid,
    input  logic [DATA_WIDTH-1:0] biu_data_out,
    output logic                  biu_busy
);

    localparam int DEPTH = 2 ** LEN_WIDTH;
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [4:0] {
        IDLE       = 5'b00001,
        WR_COLLECT = 5'b00010,
        WR_DRAIN   = 5'b00100,
        RD_REQ     = 5'b01000,
        RD_RSP     = 5'b10000
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rnw_q, rnw_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  idx_q, idx_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic [LEN_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LEN_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] fifo_q [DEPTH];

    logic                  push;
    logic [LEN_WIDTH-1:0]  push_idx;

    logic                  bus_valid;
    logic                  bus_rnw;
    logic [LEN_WIDTH-1:0]  bus_len;
    logic                  in_win;
    logic                  cs;
    logic                  unused_err;

    logic [ADDR_WIDTH-1:0] beat_off;
    logic                  drv;
    logic                  rsp;

    assign bus_valid  = bus_control[0];
    assign bus_rnw    = bus_control[1];
    assign bus_len    = bus_control[LEN_WIDTH+1:2];
    assign unused_err = bus_control[LEN_WIDTH+2];

    // Extra MSB keeps the window compare exact when the window ends at the top of memory
    assign in_win = ({1'b0, bus_address} >= {1'b0, BASE_ADDR}) &&
                    ({1'b0, bus_address} <
                     ({1'b0, BASE_ADDR} + {1'b0, ADDR_SPAN}));
    assign cs = bus_valid && in_win;

    assign beat_off = ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(ADDR_INC);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rnw_d    = rnw_q;
        len_d    = len_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        data_d   = data_q;
        err_d    = err_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        push     = 1'b0;
        push_idx = wr_ptr_q;
        biu_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cs) begin
                    addr_d   = bus_address;
                    rnw_d    = bus_rnw;
                    len_d    = bus_len;
                    data_d   = bus_data;
                    idx_d    = '0;
                    timer_d  = '0;
                    err_d    = 1'b0;
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    if (bus_rnw) begin
                        state_d = RD_REQ;
                    end else begin
                        push     = 1'b1;
                        push_idx = '0;
                        wr_ptr_d = LEN_WIDTH'(1);
                        state_d  = (bus_len == '0) ? WR_DRAIN : WR_COLLECT;
                    end
                end
            end
            WR_COLLECT: begin
                if (bus_valid) begin
                    push     = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == len_q) begin
                        state_d = WR_DRAIN;
                    end
                end
            end
            WR_DRAIN: begin
                biu_en = 1'b1;
                if (biu_ready) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    idx_d    = idx_q + 1'b1;
                    if (idx_q == len_q) begin
                        state_d = IDLE;
                    end
                end
            end
            RD_REQ: begin
                biu_en  = 1'b1;
                timer_d = timer_q + 1'b1;
                if (biu_data_valid) begin
                    data_d  = biu_data_out;
                    timer_d = '0;
                    state_d = RD_RSP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    timer_d = '0;
                    state_d = RD_RSP;
                end
            end
            RD_RSP: begin
                if (err_q || (idx_q == len_q)) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = RD_REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rnw_q    <= 1'b0;
            len_q    <= '0;
            idx_q    <= '0;
            timer_q  <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rnw_q    <= rnw_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            data_q   <= data_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push) begin
                fifo_q[push_idx] <= bus_data;
            end
        end
    end

    assign biu_busy    = (state_q != IDLE);
    assign biu_rnw     = rnw_q;
    assign biu_address = (addr_q - BASE_ADDR) + beat_off;
    assign biu_data_in = fifo_q[rd_ptr_q];

    // The bus is only ours while a read beat is pending or being returned
    assign drv = (state_q == RD_REQ) || (state_q == RD_RSP);
    assign rsp = (state_q == RD_RSP);

    assign bus_address = drv ? (addr_q + beat_off) : 'z;
    assign bus_data    = drv ? data_q : 'z;
    assign bus_control = drv ? {rsp & err_q, len_q, 1'b1, rsp} : 'z;

endmodule

// File: tb/tb_biu_slave_burst.sv
// Directed plus randomized bench for biu_slave_burst; the bench acts as
// bus master and as the slave behind the BIU, checking against a beat model.
module tb_biu_slave_burst;

    localparam int          TO   = 8;
    localparam logic [31:0] BASE = 32'h1000;
    localparam logic [31:0] SPAN = 32'h100;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    wire  [31:0] bus_address;
    wire  [31:0] bus_data;
    wire  [4:0]  bus_control;
    logic [31:0] biu_address;
    logic [31:0] biu_data_in;
    logic        biu_rnw;
    logic        biu_en;
    logic        biu_ready;
    logic        biu_data_valid;
    logic [31:0] biu_data_out;
    logic        biu_busy;

    logic        tb_oe;
    logic [31:0] tb_addr;
    logic [31:0] tb_data;
    logic [4:0]  tb_ctl;

    int checks = 0;
    int failures = 0;

    assign bus_address = tb_oe ? tb_addr : 'z;
    assign bus_data    = tb_oe ? tb_data : 'z;
    assign bus_control = tb_oe ? tb_ctl : 'z;

    biu_slave_burst #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .BASE_ADDR (BASE),
        .ADDR_SPAN (SPAN),
        .LEN_WIDTH (2),
        .ADDR_INC  (4),
        .TIMEOUT   (TO)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .bus_address   (bus_address),
        .bus_data      (bus_data),
        .bus_control   (bus_control),
        .biu_address   (biu_address),
        .biu_data_in   (biu_data_in),
        .biu_rnw       (biu_rnw),
        .biu_en        (biu_en),
        .biu_ready     (biu_ready),
        .biu_data_valid(biu_data_valid),
        .biu_data_out  (biu_data_out),
        .biu_busy      (biu_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        tb_oe   = 1'b1;
        tb_addr = $urandom;
        tb_data = $urandom;
        tb_ctl  = {4'($urandom), 1'b0};
    endtask

    task automatic chk_released(input string tag);
        #1;
        chk({tag, ".baddr"}, bus_address, tb_addr);
        chk({tag, ".bdata"}, bus_data, tb_data);
        chk({tag, ".bctl"}, bus_control, tb_ctl);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"}, biu_busy, 1'b0);
        chk({tag, ".en"}, biu_en, 1'b0);
    endtask

    task automatic drive_req(input logic [31:0] a, input logic [1:0] len,
                             input logic rnw, input logic [31:0] d);
        tb_oe   = 1'b1;
        tb_addr = a;
        tb_data = d;
        tb_ctl  = {1'b0, len, rnw, 1'b1};
    endtask

    task automatic do_write(input logic [31:0] a, input int len,
                            input logic [31:0] d [4], input bit toggle);
        int   gaps;
        int   beats;
        int   cyc;
        bit   rdy;
        bit   ph;
        drive_req(a, 2'(len), 1'b0, d[0]);
        for (int k = 1; k <= len; k++) begin
            gaps = $urandom_range(0, 2);
            repeat (gaps) begin
                @(negedge clk);
                chk("wc.en", biu_en, 1'b0);
                chk("wc.busy", biu_busy, 1'b1);
                tb_ctl[0] = 1'b0;
                tb_data   = $urandom;
            end
            @(negedge clk);
            chk("wc.en", biu_en, 1'b0);
            chk("wc.busy", biu_busy, 1'b1);
            tb_data   = d[k];
            tb_ctl[0] = 1'b1;
        end
        @(negedge clk);
        // An in-window request while draining must be ignored
        tb_addr = BASE + 32'($urandom_range(0, 63)) * 4;
        tb_data = $urandom;
        tb_ctl  = {1'b0, 2'($urandom), 1'($urandom), 1'b1};
        chk_released("wd");
        beats = 0;
        cyc   = 0;
        ph    = 1'b0;
        while (beats <= len) begin
            if (cyc >= 64) begin
                checks++;
                failures++;
                $error("FAIL wd.timeout observed=%0d expected=%0d beats",
                       beats, len + 1);
                break;
            end
            chk("wd.en", biu_en, 1'b1);
            chk("wd.rnw", biu_rnw, 1'b0);
            chk("wd.busy", biu_busy, 1'b1);
            chk("wd.addr", biu_address, a - BASE + 32'(beats) * 4);
            chk("wd.data", biu_data_in, d[beats]);
            if (toggle) begin
                rdy = ph;
                ph  = ~ph;
            end else begin
                rdy = 1'($urandom);
            end
            biu_ready = rdy;
            if (rdy) beats++;
            cyc++;
            @(negedge clk);
        end
        biu_ready = 1'b0;
        bus_idle();
        chk_idle("w.end");
        chk_released("w.end");
    endtask

    task automatic do_read(input logic [31:0] a, input int len,
                           input bit silent, input int lat_fix,
                           input logic [31:0] rd [4]);
        logic [31:0] hold;
        logic [31:0] prev;
        int          lat;
        int          c;
        bit          done;
        hold = $urandom;
        drive_req(a, 2'(len), 1'b1, hold);
        @(negedge clk);
        tb_oe = 1'b0;
        prev  = hold;
        for (int b = 0; b <= len; b++) begin
            lat  = (lat_fix < 0) ? $urandom_range(0, 5) : lat_fix;
            c    = 0;
            done = 1'b0;
            while (!done) begin
                #1;
                chk("rq.en", biu_en, 1'b1);
                chk("rq.rnw", biu_rnw, 1'b1);
                chk("rq.addr", biu_address, a - BASE + 32'(b) * 4);
                chk("rq.baddr", bus_address, a + 32'(b) * 4);
                chk("rq.bdata", bus_data, prev);
                chk("rq.bctl", bus_control, {1'b0, 2'(len), 1'b1, 1'b0});
                if (!silent && c == lat) begin
                    biu_data_valid = 1'b1;
                    biu_data_out   = rd[b];
                    done           = 1'b1;
                end else if (silent && c == TO - 1) begin
                    done = 1'b1;
                end
                c++;
                @(negedge clk);
                biu_data_valid = 1'b0;
                biu_data_out   = $urandom;
            end
            #1;
            prev = silent ? 32'h0 : rd[b];
            chk("rs.en", biu_en, 1'b0);
            chk("rs.baddr", bus_address, a + 32'(b) * 4);
            chk("rs.bdata", bus_data, prev);
            chk("rs.bctl", bus_control, {silent, 2'(len), 1'b1, 1'b1});
            // Stray slave data outside RD_REQ must not be captured
            if (1'($urandom)) begin
                biu_data_valid = 1'b1;
                biu_data_out   = $urandom;
            end
            @(negedge clk);
            biu_data_valid = 1'b0;
            if (silent) break;
        end
        chk_idle("r.end");
        bus_idle();
        chk_released("r.end");
    endtask

    task automatic oow(input logic [31:0] a);
        drive_req(a, 2'($urandom), 1'($urandom), $urandom);
        repeat (2) begin
            @(negedge clk);
            chk_idle("oow");
            chk_released("oow");
        end
        bus_idle();
    endtask

    initial begin
        logic [31:0] d [4];
        logic [31:0] a;
        int          kind;
        int          ln;

        biu_ready      = 1'b0;
        biu_data_valid = 1'b0;
        biu_data_out   = '0;
        bus_idle();
        n_rst = 1'b0;

        @(negedge clk);
        chk_idle("rst");
        chk("rst.rnw", biu_rnw, 1'b0);
        chk("rst.addr", biu_address, 32'hFFFF_F000);
        chk("rst.din", biu_data_in, 32'h0);
        chk_released("rst");
        n_rst = 1'b1;
        @(negedge clk);
        chk_idle("post_rst");

        d = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
        do_write(32'h1010, 0, d, 1'b0);

        d = '{32'd1, 32'd2, 32'd3, 32'd4};
        do_write(32'h1020, 3, d, 1'b1);

        d = '{32'hA5, 32'h5A, 32'h0, 32'h0};
        do_read(32'h1040, 1, 1'b0, 3, d);

        do_read(32'h1080, 3, 1'b1, 0, d);

        oow(32'h1100);
        oow(32'h0FFC);

        d = '{32'h1111_0000, 32'h0, 32'h0, 32'h0};
        do_write(32'h10FC, 0, d, 1'b0);

        d = '{$urandom, $urandom, $urandom, $urandom};
        do_write(32'h10F8, 3, d, 1'b0);
        do_read(32'h10F8, 3, 1'b0, -1, d);

        // Reset in the middle of a 4-beat read
        drive_req(32'h1030, 2'd3, 1'b1, $urandom);
        @(negedge clk);
        tb_oe = 1'b0;
        @(negedge clk);
        chk("mr.en", biu_en, 1'b1);
        n_rst = 1'b0;
        #1;
        chk_idle("mr");
        chk("mr.addr", biu_address, 32'hFFFF_F000);
        chk("mr.rnw", biu_rnw, 1'b0);
        bus_idle();
        chk_released("mr");
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk_idle("mr.post");
        d = '{32'hCAFE_F00D, 32'h0, 32'h0, 32'h0};
        do_write(32'h1000, 0, d, 1'b0);

        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 9);
            a    = BASE + 32'($urandom_range(0, 63)) * 4;
            ln   = $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) d[i] = $urandom;
            if (kind < 4) begin
                do_write(a, ln, d, 1'($urandom));
            end else if (kind < 8) begin
                do_read(a, ln, 1'b0, -1, d);
            end else if (kind == 8) begin
                do_read(a, ln, 1'b1, 0, d);
            end else if (1'($urandom)) begin
                oow(BASE + SPAN + 32'($urandom_range(0, 100)) * 4);
            end else begin
                oow(BASE - 32'($urandom_range(1, 100)) * 4);
            end
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk_idle("gap");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
